// File: rtl/lsu_lsq_ring_if.sv
// Bundle of the LSQ ring's dispatch, DTLB, wakeup, issue, response and retire signals.
interface lsu_lsq_ring_if #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned PTR_W    = $clog2(DEPTH),
  parameter int unsigned VTAG_W   = 20,
  parameter int unsigned TAG_W    = 28,
  parameter int unsigned PLD_W    = 64,
  parameter int unsigned ECAUSE_W = 5
) ();

  logic                flush_i;

  logic                enq_vld_i;
  logic                enq_rdy_o;
  logic                enq_ls_i;
  logic                enq_fenced_i;
  logic                enq_awake_i;
  logic [VTAG_W-1:0]   enq_vtag_i;
  logic [PLD_W-1:0]    enq_pld_i;
  logic                enq_exc_i;
  logic [ECAUSE_W-1:0] enq_ecause_i;
  logic [PTR_W-1:0]    enq_idx_o;

  logic                tlb_vld_i;
  logic [PTR_W-1:0]    tlb_idx_i;
  logic [TAG_W-1:0]    tlb_tag_i;
  logic                tlb_exc_i;
  logic [ECAUSE_W-1:0] tlb_ecause_i;

  logic                wake_vld_i;
  logic [PTR_W-1:0]    wake_idx_i;

  logic                iss_vld_o;
  logic                iss_rdy_i;
  logic [PTR_W-1:0]    iss_idx_o;
  logic                iss_ls_o;
  logic [TAG_W-1:0]    iss_tag_o;
  logic [PLD_W-1:0]    iss_pld_o;

  logic                resp_vld_i;
  logic [PTR_W-1:0]    resp_idx_i;
  logic                resp_replay_i;

  logic                deq_vld_o;
  logic                deq_rdy_i;
  logic                deq_ls_o;
  logic [PLD_W-1:0]    deq_pld_o;
  logic                deq_exc_o;
  logic [ECAUSE_W-1:0] deq_ecause_o;

  logic [PTR_W:0]      count_o;

  // Queue side.
  modport slave (
    input  flush_i,
    input  enq_vld_i, enq_ls_i, enq_fenced_i, enq_awake_i, enq_vtag_i, enq_pld_i,
    input  enq_exc_i, enq_ecause_i,
    output enq_rdy_o, enq_idx_o,
    input  tlb_vld_i, tlb_idx_i, tlb_tag_i, tlb_exc_i, tlb_ecause_i,
    input  wake_vld_i, wake_idx_i,
    output iss_vld_o, iss_idx_o, iss_ls_o, iss_tag_o, iss_pld_o,
    input  iss_rdy_i,
    input  resp_vld_i, resp_idx_i, resp_replay_i,
    output deq_vld_o, deq_ls_o, deq_pld_o, deq_exc_o, deq_ecause_o,
    input  deq_rdy_i,
    output count_o
  );

  // Dispatch / DTLB / LSU pipe side.
  modport master (
    output flush_i,
    output enq_vld_i, enq_ls_i, enq_fenced_i, enq_awake_i, enq_vtag_i, enq_pld_i,
    output enq_exc_i, enq_ecause_i,
    input  enq_rdy_o, enq_idx_o,
    output tlb_vld_i, tlb_idx_i, tlb_tag_i, tlb_exc_i, tlb_ecause_i,
    output wake_vld_i, wake_idx_i,
    input  iss_vld_o, iss_idx_o, iss_ls_o, iss_tag_o, iss_pld_o,
    output iss_rdy_i,
    output resp_vld_i, resp_idx_i, resp_replay_i,
    input  deq_vld_o, deq_ls_o, deq_pld_o, deq_exc_o, deq_ecause_o,
    output deq_rdy_i,
    input  count_o
  );

endinterface

// File: rtl/lsu_lsq_ring.sv
// Circular load/store queue: in-order allocate, oldest-ready out-of-order issue with fence
// ordering and replay, in-order retire from head.
module lsu_lsq_ring #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned PTR_W    = $clog2(DEPTH),
  parameter int unsigned VTAG_W   = 20,
  parameter int unsigned TAG_W    = 28,
  parameter int unsigned PLD_W    = 64,
  parameter int unsigned ECAUSE_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  lsu_lsq_ring_if.slave   bus
);

  // Pointers carry a wrap bit above the slot index.
  logic [PTR_W:0]   head_q, head_d;
  logic [PTR_W:0]   tail_q, tail_d;
  logic [PTR_W-1:0] head_idx, tail_idx;

  // Per-entry flags, one bit per slot.
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] ls_q, ls_d;
  logic [DEPTH-1:0] fenced_q, fenced_d;
  logic [DEPTH-1:0] awake_q, awake_d;
  logic [DEPTH-1:0] virt_q, virt_d;
  logic [DEPTH-1:0] exec_q, exec_d;
  logic [DEPTH-1:0] succ_q, succ_d;
  logic [DEPTH-1:0] exc_q, exc_d;

  // Per-entry data.
  logic [ECAUSE_W-1:0] ecause_q [DEPTH];
  logic [ECAUSE_W-1:0] ecause_d [DEPTH];
  logic [TAG_W-1:0]    tag_q    [DEPTH];
  logic [TAG_W-1:0]    tag_d    [DEPTH];
  logic [PLD_W-1:0]    pld_q    [DEPTH];
  logic [PLD_W-1:0]    pld_d    [DEPTH];

  logic             full;
  logic             enq_fire;
  logic             iss_fire;
  logic             deq_vld;
  logic             deq_fire;
  logic [DEPTH-1:0] base_elig;
  logic             iss_found;
  logic [PTR_W-1:0] iss_sel;
  logic             fence_block;
  logic [PTR_W-1:0] scan_idx;

  assign head_idx = head_q[PTR_W-1:0];
  assign tail_idx = tail_q[PTR_W-1:0];
  assign full     = (head_idx == tail_idx) && (head_q[PTR_W] != tail_q[PTR_W]);

  assign enq_fire = bus.enq_vld_i & ~full;
  assign deq_vld  = vld_q[head_idx] & (succ_q[head_idx] | exc_q[head_idx]);
  assign deq_fire = deq_vld & bus.deq_rdy_i;
  assign iss_fire = iss_found & bus.iss_rdy_i;

  // Entry-local readiness, before the ordering constraints.
  assign base_elig = vld_q & awake_q & ~virt_q & ~exec_q & ~succ_q & ~exc_q;

  // Oldest-first scan from head; a pending fence blocks everything younger than it,
  // and a fenced entry itself may only go from head.
  always_comb begin
    iss_found   = 1'b0;
    iss_sel     = '0;
    fence_block = 1'b0;
    scan_idx    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      scan_idx = head_idx + PTR_W'(i);
      if (!iss_found && !fence_block && base_elig[scan_idx] &&
          (!fenced_q[scan_idx] || i == 0)) begin
        iss_found = 1'b1;
        iss_sel   = scan_idx;
      end
      if (vld_q[scan_idx] && fenced_q[scan_idx] && !succ_q[scan_idx]) begin
        fence_block = 1'b1;
      end
    end
  end

  // Next-state: fill, wakeup, issue, response, retire, enqueue; flush overrides all.
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    vld_d    = vld_q;
    ls_d     = ls_q;
    fenced_d = fenced_q;
    awake_d  = awake_q;
    virt_d   = virt_q;
    exec_d   = exec_q;
    succ_d   = succ_q;
    exc_d    = exc_q;
    ecause_d = ecause_q;
    tag_d    = tag_q;
    pld_d    = pld_q;

    if (bus.tlb_vld_i && vld_q[bus.tlb_idx_i]) begin
      tag_d[bus.tlb_idx_i]  = bus.tlb_tag_i;
      virt_d[bus.tlb_idx_i] = 1'b0;
      if (bus.tlb_exc_i) begin
        exc_d[bus.tlb_idx_i]    = 1'b1;
        ecause_d[bus.tlb_idx_i] = bus.tlb_ecause_i;
      end
    end

    if (bus.wake_vld_i && vld_q[bus.wake_idx_i]) begin
      awake_d[bus.wake_idx_i] = 1'b1;
    end

    if (iss_fire) begin
      exec_d[iss_sel] = 1'b1;
    end

    // Replay only drops exec; awake and the physical tag survive for re-issue.
    if (bus.resp_vld_i && vld_q[bus.resp_idx_i] && exec_q[bus.resp_idx_i]) begin
      exec_d[bus.resp_idx_i] = 1'b0;
      if (!bus.resp_replay_i) begin
        succ_d[bus.resp_idx_i] = 1'b1;
      end
    end

    if (deq_fire) begin
      vld_d[head_idx] = 1'b0;
      head_d          = head_q + 1'b1;
    end

    // Tail slot is always invalid when not full, so this never collides with the above.
    if (enq_fire) begin
      vld_d[tail_idx]    = 1'b1;
      ls_d[tail_idx]     = bus.enq_ls_i;
      fenced_d[tail_idx] = bus.enq_fenced_i;
      awake_d[tail_idx]  = bus.enq_awake_i;
      virt_d[tail_idx]   = 1'b1;
      exec_d[tail_idx]   = 1'b0;
      succ_d[tail_idx]   = 1'b0;
      exc_d[tail_idx]    = bus.enq_exc_i;
      ecause_d[tail_idx] = bus.enq_ecause_i;
      tag_d[tail_idx]    = TAG_W'(bus.enq_vtag_i);
      pld_d[tail_idx]    = bus.enq_pld_i;
      tail_d             = tail_q + 1'b1;
    end

    if (bus.flush_i) begin
      vld_d  = '0;
      exec_d = '0;
      succ_d = '0;
      head_d = '0;
      tail_d = '0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      vld_q    <= '0;
      ls_q     <= '0;
      fenced_q <= '0;
      awake_q  <= '0;
      virt_q   <= '0;
      exec_q   <= '0;
      succ_q   <= '0;
      exc_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ecause_q[i] <= '0;
        tag_q[i]    <= '0;
        pld_q[i]    <= '0;
      end
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      vld_q    <= vld_d;
      ls_q     <= ls_d;
      fenced_q <= fenced_d;
      awake_q  <= awake_d;
      virt_q   <= virt_d;
      exec_q   <= exec_d;
      succ_q   <= succ_d;
      exc_q    <= exc_d;
      ecause_q <= ecause_d;
      tag_q    <= tag_d;
      pld_q    <= pld_d;
    end
  end

  // Outputs; issue and retire contents are zeroed when not valid.
  always_comb begin
    bus.enq_rdy_o    = ~full;
    bus.enq_idx_o    = tail_idx;
    bus.count_o      = tail_q - head_q;

    bus.iss_vld_o    = iss_found;
    bus.iss_idx_o    = '0;
    bus.iss_ls_o     = 1'b0;
    bus.iss_tag_o    = '0;
    bus.iss_pld_o    = '0;
    if (iss_found) begin
      bus.iss_idx_o  = iss_sel;
      bus.iss_ls_o   = ls_q[iss_sel];
      bus.iss_tag_o  = tag_q[iss_sel];
      bus.iss_pld_o  = pld_q[iss_sel];
    end

    bus.deq_vld_o    = deq_vld;
    bus.deq_ls_o     = 1'b0;
    bus.deq_pld_o    = '0;
    bus.deq_exc_o    = 1'b0;
    bus.deq_ecause_o = '0;
    if (deq_vld) begin
      bus.deq_ls_o     = ls_q[head_idx];
      bus.deq_pld_o    = pld_q[head_idx];
      bus.deq_exc_o    = exc_q[head_idx];
      bus.deq_ecause_o = ecause_q[head_idx];
    end
  end

endmodule
